vote_tally_seq: RTL
===================

// Module: vote_tally_seq
// PURPOSE
//  Sequential, parametrised successor to the 4-input combinational vote circuit (majority and tie flags).
//  Opens a ballot and accepts one yes/no vote per voter ID over successive cycles; rejects duplicates.
//  Closes on all-voted, explicit close or timeout, then presents win/tie plus yes/no counts on a ready/valid result port.
//  Sits between the voter interface logic and the downstream decision/reporting logic.
// PARAMETERS
//  N_VOTERS  4   number of voters; legal range 2..256
//  TIMEOUT   64  cycles in COLLECT before forced close; 0 disables the timeout
//  ID_W      derived = max(1,$clog2(N_VOTERS)); width of vote_id
//  CNT_W     derived = $clog2(N_VOTERS+1); width of the count outputs
// PORTS
//  clk           in   1      single clock; all logic on posedge
//  rst_n         in   1      synchronous reset, active-low
//  start         in   1      pulse; opens a ballot (used in IDLE only)
//  vote_valid    in   1      vote present this cycle
//  vote_id       in   ID_W   voter index
//  vote_val      in   1      1 = yes, 0 = no
//  vote_ready    out  1      1 while in COLLECT; vote accepted when vote_valid & vote_ready
//  close         in   1      pulse; forces ballot end (used in COLLECT only)
//  busy          out  1      state != IDLE
//  result_valid  out  1      result held stable while 1
//  result_ready  in   1      downstream accept
//  win           out  1      yes_cnt > no_cnt
//  tie           out  1      yes_cnt == no_cnt (includes 0 == 0)
//  yes_cnt       out  CNT_W  accepted yes votes
//  no_cnt        out  CNT_W  accepted no votes
//  timed_out     out  1      result was produced by timeout; valid with result_valid
//  vote_err      out  1      1-cycle pulse: duplicate or out-of-range vote rejected
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge): state=IDLE; voted bitmap, counts and timer = 0.
//   All outputs 0, except tie=1 (0==0). Reset mid-ballot discards the ballot silently.
//  FSM IDLE -> COLLECT: on start. Clears bitmap, counts, timer and timed_out in the same edge.
//  FSM COLLECT -> RESULT when any of these hold:
//   (a) the bitmap becomes full, including via the vote accepted this cycle;
//   (b) close=1;
//   (c) TIMEOUT != 0 and timer reaches TIMEOUT-1.
//  FSM RESULT -> IDLE on result_valid & result_ready.
//  Latency: vote accepted at edge k updates counts at k; if it completes the ballot, result_valid=1 after edge k+1.
//  Vote acceptance, in COLLECT only:
//   - id < N_VOTERS and bit clear: set bit; increment yes_cnt or no_cnt.
//   - id already voted, or id >= N_VOTERS: no count change; vote_err pulses next cycle.
//  A vote and close in the same cycle: the vote is counted, then the ballot closes.
//  Timeout and close in the same cycle: timed_out=0 (close has priority).
//  start while busy: ignored. close outside COLLECT: ignored. vote_valid outside COLLECT: ignored, no vote_err.
//  win/tie are registered from the counts; stable throughout RESULT.
//   In IDLE and COLLECT they track the live counts, so they are meaningful only with result_valid.
//  Counts never wrap: at most N_VOTERS votes are accepted, and CNT_W holds N_VOTERS exactly.
//  Timer counts COLLECT cycles from 0; it is held and not wrapped once the ballot closes.
// STRUCTURE
//  Package vote_pkg holds:
//   - state typedef {IDLE, COLLECT, RESULT}, 2-bit encoding;
//   - clog2-based width helper functions;
//   - vote_err cause localparams (DUP, RANGE) for bench coverage.
//  Sub-module vote_counter: CNT_W up-counter with synchronous clear and enable.
//   Instanced twice (yes, no). FSM, bitmap and timer stay in the top.
// TESTING
//  T1 exhaustive parity with the 4-input circuit: N=4; for each of the 16 patterns, start, vote ids 0..3 with vote_val=bit.
//   -> result_valid at all-voted+1; win = popcount>2, tie = popcount==2.
//  T2 duplicate: N=4; start; votes id1=1, id1=0, id2=1.
//   -> vote_err one pulse after the 2nd vote; yes_cnt=2, no_cnt=0.
//  T3 timeout: N=4, TIMEOUT=8; start; one yes vote, then idle.
//   -> result_valid after 8 COLLECT cycles; timed_out=1; yes=1, no=0, win=1.
//  T4 close and vote same cycle: vote id0=0 with close=1.
//   -> no_cnt=1, tie=0, win=0, timed_out=0; later votes ignored.
//  T5 backpressure: hold result_ready=0 for 5 cycles.
//   -> outputs stable and start ignored; on ready=1 return to IDLE; a new start then clears counts.
//  T6 reset mid-ballot: rst_n=0 for 1 cycle after 2 votes.
//   -> busy=0, counts 0, tie=1; a fresh ballot accepts the same voter IDs again.

Source files
------------

// File: rtl/vote_pkg.sv
// vote_pkg: shared state encoding, width helpers and reject-cause codes for the vote tally
package vote_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, RESULT = 2'd2} state_t;
   localparam int DUP = 0;
   localparam int RANGE = 1;
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/vote_counter.sv
// vote_counter: W-bit up-counter with synchronous clear and enable
module vote_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);
   // clear wins over increment so a new ballot always starts from zero
   always_ff @(posedge clk)
      if (!rst_n || clr) cnt <= '0;
      else if (en) cnt <= cnt + W'(1);
endmodule

// File: rtl/vote_tally_seq.sv
// vote_tally_seq: sequential ballot with duplicate rejection, close/timeout and ready/valid result
module vote_tally_seq import vote_pkg::*; #(
   parameter int N_VOTERS = 4,
   parameter int TIMEOUT = 64,
   localparam int ID_W = clog2_min1(N_VOTERS),
   localparam int CNT_W = cnt_width(N_VOTERS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vote_valid,
   input  logic [ID_W-1:0]  vote_id,
   input  logic             vote_val,
   output logic             vote_ready,
   input  logic             close,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             win,
   output logic             tie,
   output logic [CNT_W-1:0] yes_cnt,
   output logic [CNT_W-1:0] no_cnt,
   output logic             timed_out,
   output logic             vote_err
);
   localparam int TW = clog2_min1(TIMEOUT + 1);
   state_t state, state_nx;
   logic [N_VOTERS-1:0] voted, hit, voted_nx;
   logic [TW-1:0] timer;
   logic open, in_range, accept, reject, full, to_hit, done, clr;
   // next-state, vote acceptance and close conditions
   always_comb begin
      open = state == COLLECT;
      in_range = int'(vote_id) < N_VOTERS;
      accept = open && vote_valid && in_range && !voted[vote_id];
      reject = open && vote_valid && !accept;
      hit = accept ? (N_VOTERS'(1) << vote_id) : '0;
      voted_nx = voted | hit;
      full = &voted_nx;
      to_hit = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));
      done = result_valid && result_ready;
      clr = (state == IDLE) && start;
      state_nx = clr ? COLLECT :
                 (open && (full || close || to_hit)) ? RESULT :
                 done ? IDLE : state;
      busy = state != IDLE;
      vote_ready = open;
   end
   // state register
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // bitmap, timer, result flags; result_valid lags RESULT entry so win/tie see final counts
   always_ff @(posedge clk)
      if (!rst_n) begin
         voted <= '0;
         timer <= '0;
         timed_out <= 1'b0;
         vote_err <= 1'b0;
         result_valid <= 1'b0;
         win <= 1'b0;
         tie <= 1'b1;
      end else begin
         vote_err <= reject;
         win <= yes_cnt > no_cnt;
         tie <= yes_cnt == no_cnt;
         result_valid <= (state == RESULT) && !done;
         if (clr) begin
            voted <= '0;
            timer <= '0;
            timed_out <= 1'b0;
         end else if (open) begin
            voted <= voted_nx;
            timer <= timer + TW'(state_nx == COLLECT);
            timed_out <= to_hit && !close && !full;
         end
      end
   vote_counter #(.W(CNT_W)) u_yes (
      .clk(clk), .rst_n(rst_n), .clr(clr), .en(accept && vote_val), .cnt(yes_cnt)
   );
   vote_counter #(.W(CNT_W)) u_no (
      .clk(clk), .rst_n(rst_n), .clr(clr), .en(accept && !vote_val), .cnt(no_cnt)
   );
endmodule
